// File: rtl/profile_cache_counters.sv
// profile_cache_counters: saturating icache/dcache event counters behind a one-outstanding read port.
// Optional coherent snapshot shadows are enabled by CLAP_CONFIG_CACHE_PROFILE_SNAPSHOT_EN.
module profile_cache_counters #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        clr,
    input  logic        icache_valid,
    input  logic        icache_hit,
    input  logic        dcache_valid,
    input  logic        dcache_hit,
    input  logic        rd_req,
    input  logic [2:0]  rd_sel,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_next;
    logic [CNT_W-1:0] cnt [5];
    logic [4:0] ovf;
    logic [4:0] inc;
    logic [31:0] view [8];
    logic accept;

    assign inc = {en, en & dcache_valid & ~dcache_hit, en & dcache_valid,
                  en & icache_valid & ~icache_hit, en & icache_valid};
    assign accept = rd_req & rd_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
            ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
            ovf <= '0;
        end else begin
            for (int i = 0; i < 5; i++)
                if (inc[i]) begin
                    if (&cnt[i]) ovf[i] <= 1'b1;
                    else cnt[i] <= cnt[i] + CNT_W'(1);
                end
        end
    end

`ifdef CLAP_CONFIG_CACHE_PROFILE_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow [1:4];
    logic [4:0] shadow_ovf;

    // Sel 0 acceptance freezes a coherent sample for the later sel 1..5 reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i < 5; i++) shadow[i] <= '0;
            shadow_ovf <= '0;
        end else if (accept && rd_sel == 3'd0) begin
            for (int i = 1; i < 5; i++) shadow[i] <= cnt[i];
            shadow_ovf <= ovf;
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < 8; i++) view[i] = '0;
        for (int i = 0; i < 5; i++) view[i] = 32'(cnt[i]);
        view[5] = {27'b0, ovf};
`ifdef CLAP_CONFIG_CACHE_PROFILE_SNAPSHOT_EN
        for (int i = 1; i < 5; i++) view[i] = 32'(shadow[i]);
        view[5] = {27'b0, shadow_ovf};
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rd_data <= '0;
        end else begin
            state <= state_next;
            if (accept) rd_data <= view[rd_sel];
        end
    end

    always_comb begin
        rd_ready   = state == IDLE;
        rd_valid   = state == RESP;
        state_next = (state == IDLE && rd_req) ? RESP : IDLE;
    end
endmodule
